// File: rtl/dram_ctrl_pkg.sv
// dram_ctrl_pkg: shared definitions for the DRAM initiator.
//   - request/pin field widths and row/column slicing helpers
//   - FSM state encodings
//   - pin command tuples {RASn, CASn, WEn}
package dram_ctrl_pkg;

  localparam int unsigned AddrW  = 21;
  localparam int unsigned RowW   = 11;
  localparam int unsigned ColW   = 10;
  localparam int unsigned PinAW  = 11;
  localparam int unsigned DataW  = 32;
  localparam int unsigned StrbW  = 4;
  localparam int unsigned TimerW = 8;

  localparam int unsigned StateW = 4;
  localparam logic [StateW-1:0] StIdle    = 4'd0;
  localparam logic [StateW-1:0] StPre     = 4'd1;
  localparam logic [StateW-1:0] StPreWait = 4'd2;
  localparam logic [StateW-1:0] StAct     = 4'd3;
  localparam logic [StateW-1:0] StActWait = 4'd4;
  localparam logic [StateW-1:0] StRd      = 4'd5;
  localparam logic [StateW-1:0] StRdWait  = 4'd6;
  localparam logic [StateW-1:0] StWr      = 4'd7;
  localparam logic [StateW-1:0] StWrWait  = 4'd8;

  typedef struct packed {
    logic             ras_n;
    logic             cas_n;
    logic [StrbW-1:0] wen;
  } cmd_t;

  localparam cmd_t CmdNop = '{ras_n: 1'b1, cas_n: 1'b1, wen: 4'hF};
  localparam cmd_t CmdPre = '{ras_n: 1'b0, cas_n: 1'b1, wen: 4'h0};
  localparam cmd_t CmdAct = '{ras_n: 1'b0, cas_n: 1'b1, wen: 4'hF};
  localparam cmd_t CmdRd  = '{ras_n: 1'b1, cas_n: 1'b0, wen: 4'hF};
  // WEn of a write is replaced by the inverted byte strobes.
  localparam cmd_t CmdWr  = '{ras_n: 1'b1, cas_n: 1'b0, wen: 4'h0};

  function automatic logic [RowW-1:0] addr_row(input logic [AddrW-1:0] addr);
    return addr[AddrW-1:ColW];
  endfunction

  function automatic logic [PinAW-1:0] addr_col(input logic [AddrW-1:0] addr);
    return {1'b0, addr[ColW-1:0]};
  endfunction

endpackage

// File: rtl/dram_timer.sv
// dram_timer: loadable down-counter used for the DRAM wait states.
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   load_i     load load_val_i on the next edge
//   load_val_i value to count down from
//   done_o     high while the count is zero
module dram_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/dram_ctrl.sv
// dram_ctrl: single-word open-page DRAM initiator.
//   clk, rst                 controller clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in idle)
//   req_write/addr/wdata/wstrb  request payload; row = addr[20:10], col = addr[9:0]
//   rsp_valid, rsp_rdata     one-cycle completion pulse, read data held between reads
//   DRAM_CSn/RASn/CASn/WEn/A/D  registered DRAM command pins
//   DRAM_Q, DRAM_valid       read data return
// Pin outputs are registered from the current state, so a command state in cycle n
// shows on the pins in cycle n+1.
module dram_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int unsigned T_RCD = 5,  // must be >= 2
  parameter int unsigned T_RP  = 5,  // must be >= 2
  parameter int unsigned T_WR  = 5   // must be >= 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [20:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        DRAM_CSn,
  output logic        DRAM_RASn,
  output logic        DRAM_CASn,
  output logic [3:0]  DRAM_WEn,
  output logic [10:0] DRAM_A,
  output logic [31:0] DRAM_D,
  input  logic [31:0] DRAM_Q,
  input  logic        DRAM_valid
);

  // The command state itself counts as the first cycle of each delay.
  localparam logic [TimerW-1:0] RpLoad  = TimerW'(T_RP - 2);
  localparam logic [TimerW-1:0] RcdLoad = TimerW'(T_RCD - 2);
  localparam logic [TimerW-1:0] WrLoad  = TimerW'(T_WR - 2);

  logic [StateW-1:0] state_q, state_d;

  logic             wr_q;
  logic [AddrW-1:0] addr_q;
  logic [DataW-1:0] wdata_q;
  logic [StrbW-1:0] wstrb_q;

  logic            row_open_q;
  logic [RowW-1:0] open_row_q;

  // Write completion is staged one cycle so rsp_valid lines up with the pins.
  logic cmp_q, cmp_d;
  logic rsp_valid_q, rsp_valid_d;
  logic [DataW-1:0] rsp_rdata_q;

  cmd_t             cmd_q, cmd_d;
  logic             csn_q, csn_d;
  logic [PinAW-1:0] a_q, a_d;
  logic [DataW-1:0] d_q, d_d;

  logic              timer_load;
  logic [TimerW-1:0] timer_val;
  logic              timer_done;

  logic accept;
  logic row_hit;
  logic rd_done;

  assign req_ready = (state_q == StIdle) && !cmp_q && !rsp_valid_q;
  assign accept    = req_valid && req_ready;
  assign row_hit   = row_open_q && (open_row_q == addr_row(req_addr));
  assign rd_done   = (state_q == StRdWait) && DRAM_valid;

  dram_timer #(
    .Width(TimerW)
  ) u_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (timer_load),
    .load_val_i(timer_val),
    .done_o    (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    cmp_d      = 1'b0;
    timer_load = 1'b0;
    timer_val  = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_write && (req_wstrb == '0)) begin
            cmp_d = 1'b1;  // nothing to write, complete without touching DRAM
          end else if (row_hit) begin
            state_d = req_write ? StWr : StRd;
          end else if (row_open_q) begin
            state_d = StPre;
          end else begin
            state_d = StAct;
          end
        end
      end
      StPre: begin
        state_d    = StPreWait;
        timer_load = 1'b1;
        timer_val  = RpLoad;
      end
      StPreWait: if (timer_done) state_d = StAct;
      StAct: begin
        state_d    = StActWait;
        timer_load = 1'b1;
        timer_val  = RcdLoad;
      end
      StActWait: if (timer_done) state_d = wr_q ? StWr : StRd;
      StRd:      state_d = StRdWait;
      StRdWait:  if (DRAM_valid) state_d = StIdle;
      StWr: begin
        state_d    = StWrWait;
        timer_load = 1'b1;
        timer_val  = WrLoad;
      end
      StWrWait: begin
        if (timer_done) begin
          state_d = StIdle;
          cmp_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rsp_valid_d = cmp_q || rd_done;

  // Pin next-state: A and D only change on commands that define them.
  always_comb begin
    csn_d = (state_q == StIdle);
    cmd_d = CmdNop;
    a_d   = a_q;
    d_d   = d_q;
    case (state_q)
      StPre: cmd_d = CmdPre;
      StAct: begin
        cmd_d = CmdAct;
        a_d   = addr_row(addr_q);
      end
      StRd: begin
        cmd_d = CmdRd;
        a_d   = addr_col(addr_q);
      end
      StWr: begin
        cmd_d     = CmdWr;
        cmd_d.wen = ~wstrb_q;
        a_d       = addr_col(addr_q);
        d_d       = wdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      row_open_q  <= 1'b0;
      open_row_q  <= '0;
      cmp_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      cmd_q       <= CmdNop;
      csn_q       <= 1'b1;
      a_q         <= '0;
      d_q         <= '0;
    end else begin
      state_q     <= state_d;
      cmp_q       <= cmp_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_q       <= cmd_d;
      csn_q       <= csn_d;
      a_q         <= a_d;
      d_q         <= d_d;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
      if (state_q == StAct) begin
        row_open_q <= 1'b1;
        open_row_q <= addr_row(addr_q);
      end
      if (rd_done) begin
        rsp_rdata_q <= DRAM_Q;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign DRAM_CSn  = csn_q;
  assign DRAM_RASn = cmd_q.ras_n;
  assign DRAM_CASn = cmd_q.cas_n;
  assign DRAM_WEn  = cmd_q.wen;
  assign DRAM_A    = a_q;
  assign DRAM_D    = d_q;

endmodule
